// File: rtl/vape_mem_arbiter_if.sv
// Memory-port handshake bundle between CPU/DMA requesters and the arbiter.
// master: requester side (req/addr/wr out, grants and memory strobes in).
// slave:  arbiter side (req/addr/wr in, grants and memory strobes out).
interface vape_mem_arbiter_if;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_wr;
  logic        cpu_gnt;
  logic        dma_gnt;
  logic        dma_blocked;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;

  modport master (
    output cpu_req, cpu_addr, cpu_wr,
    output dma_req, dma_addr, dma_wr,
    input  cpu_gnt, dma_gnt, dma_blocked,
    input  mem_en, mem_wr, mem_addr
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wr,
    input  dma_req, dma_addr, dma_wr,
    output cpu_gnt, dma_gnt, dma_blocked,
    output mem_en, mem_wr, mem_addr
  );
endinterface

// File: rtl/vape_mem_arbiter.sv
// CPU/DMA arbiter for the single-port data memory, one beat per cycle.
// CPU has priority; DMA gets bounded bursts and a starvation handover.
// Ports: clk, rst (async, active-high), exec, OR_min, OR_max,
//        bus (vape_mem_arbiter_if.slave: requests in, grants/mem out).
// Optional: VAPE_DMA_OR_GUARD_EN stalls DMA writes into [OR_min,OR_max]
// while exec is set; undefined ties dma_blocked low.
module vape_mem_arbiter #(
  parameter int DMA_BURST_MAX  = 4,
  parameter int CPU_STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exec,
  input  logic [15:0]           OR_min,
  input  logic [15:0]           OR_max,
  vape_mem_arbiter_if.slave     bus
);
  localparam int BW = $clog2(DMA_BURST_MAX + 1);
  localparam int WW = $clog2(CPU_STARVE_MAX + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(DMA_BURST_MAX - 1);
  localparam logic [BW-1:0] BURST_TOP  = BW'(DMA_BURST_MAX);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(CPU_STARVE_MAX - 1);
  localparam logic [WW-1:0] WAIT_TOP   = WW'(CPU_STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  owner_t        owner;
  owner_t        owner_nxt;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic          blocked;
  logic          dma_eff;
  logic          cpu_gnt;
  logic          dma_gnt;

`ifdef VAPE_DMA_OR_GUARD_EN
  assign blocked = bus.dma_req & bus.dma_wr & exec
                 & (bus.dma_addr >= OR_min)
                 & (bus.dma_addr <= OR_max);
`else
  logic unused_guard;
  assign blocked      = 1'b0;
  assign unused_guard = ^{exec, OR_min, OR_max};
`endif

  assign dma_eff = bus.dma_req & ~blocked;
  assign cpu_gnt = bus.cpu_req & (owner == OWN_CPU);
  assign dma_gnt = dma_eff & (owner == OWN_DMA);

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.dma_gnt     = dma_gnt;
  assign bus.dma_blocked = blocked;
  assign bus.mem_en      = cpu_gnt | dma_gnt;
  assign bus.mem_wr      = cpu_gnt ? bus.cpu_wr
                                   : (dma_gnt & bus.dma_wr);
  assign bus.mem_addr    = (owner == OWN_DMA) ? bus.dma_addr :
                           (owner == OWN_CPU) ? bus.cpu_addr :
                                                16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_NONE;
      burst_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      owner     <= owner_nxt;
      burst_cnt <= burst_nxt;
      wait_cnt  <= wait_nxt;
    end
  end

  always_comb begin
    owner_nxt = owner;
    burst_nxt = burst_cnt;
    wait_nxt  = wait_cnt;

    unique case (owner)
      OWN_NONE: begin
        if (bus.cpu_req)  owner_nxt = OWN_CPU;
        else if (dma_eff) owner_nxt = OWN_DMA;
        else              owner_nxt = OWN_NONE;
      end
      OWN_CPU: begin
        if (dma_eff && wait_cnt == WAIT_LAST)
          owner_nxt = OWN_DMA;
        else if (!bus.cpu_req)
          owner_nxt = dma_eff ? OWN_DMA : OWN_NONE;
      end
      OWN_DMA: begin
        if (dma_gnt && burst_cnt >= BURST_LAST && bus.cpu_req)
          owner_nxt = OWN_CPU;
        else if (!dma_eff)
          owner_nxt = bus.cpu_req ? OWN_CPU : OWN_NONE;
      end
      default: owner_nxt = OWN_NONE;
    endcase

    if (dma_gnt && burst_cnt != BURST_TOP)
      burst_nxt = burst_cnt + 1'b1;
    if (owner_nxt == OWN_DMA && owner != OWN_DMA)
      burst_nxt = '0;

    // The cycle a request is first seen from idle is arbitration, not
    // waiting, so only cycles spent behind the CPU count; this gives the
    // CPU_STARVE_MAX+1 worst-case wait.
    if (!dma_eff || dma_gnt)
      wait_nxt = '0;
    else if (owner == OWN_CPU && wait_cnt != WAIT_TOP)
      wait_nxt = wait_cnt + 1'b1;
  end
endmodule

// File: tb/tb_vape_mem_arbiter.sv
// Self-checking bench for vape_mem_arbiter: expected memory beats are
// queued as stimulus is driven and popped by a monitor as beats appear.
module tb_vape_mem_arbiter;
  logic        clk;
  logic        rst;
  logic        exec;
  logic [15:0] or_min;
  logic [15:0] or_max;
  int          checks;
  int          errors;

  typedef struct packed {
    logic        dma;
    logic [15:0] addr;
    logic        wr;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  vape_mem_arbiter_if bus();

  vape_mem_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .exec   (exec),
    .OR_min (or_min),
    .OR_max (or_max),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (!rst && bus.mem_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got dma=%0d addr=%h wr=%0d",
                 bus.dma_gnt, bus.mem_addr, bus.mem_wr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.dma_gnt, bus.mem_addr, bus.mem_wr} !== mon_e) begin
          errors++;
          $display("FAIL beat got dma=%0d addr=%h wr=%0d exp dma=%0d addr=%h wr=%0d",
                   bus.dma_gnt, bus.mem_addr, bus.mem_wr,
                   mon_e.dma, mon_e.addr, mon_e.wr);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic d, input logic [15:0] a,
                      input logic w);
    beat_t b;
    b.dma  = d;
    b.addr = a;
    b.wr   = w;
    exp_q.push_back(b);
  endtask

  task automatic idle;
    tick;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    exec         = 1'b0;
    or_min       = 16'h0200;
    or_max       = 16'h02FF;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'hBEEF;
    bus.cpu_wr   = 1'b1;
    bus.dma_req  = 1'b1;
    bus.dma_addr = 16'hCAFE;
    bus.dma_wr   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.cpu_gnt, bus.dma_gnt, bus.dma_blocked,
         bus.mem_en, bus.mem_wr, bus.mem_addr} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0",
               {bus.cpu_gnt, bus.dma_gnt, bus.dma_blocked,
                bus.mem_en, bus.mem_wr, bus.mem_addr});
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.mem_addr} !== 17'd0) begin
      errors++;
      $display("FAIL idle_after_reset got en=%0d addr=%h exp 0",
               bus.mem_en, bus.mem_addr);
    end
  endtask

  task automatic test_cpu_single;
    tick;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h1234;
    bus.cpu_wr   = 1'b1;
    push(1'b0, 16'h1234, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL cpu_latency_c0 got %0d exp 0", bus.cpu_gnt);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({bus.cpu_gnt, bus.mem_addr, bus.mem_wr} !== {1'b1, 16'h1234, 1'b1})
    begin
      errors++;
      $display("FAIL cpu_grant_c1 got g=%0d a=%h w=%0d exp 1 1234 1",
               bus.cpu_gnt, bus.mem_addr, bus.mem_wr);
    end
    tick;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL cpu_release got en=%0d exp 0", bus.mem_en);
    end
    idle;
  endtask

  task automatic test_starvation;
    logic ec;
    logic ed;
    tick;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0A00;
    bus.cpu_wr   = 1'b1;
    bus.dma_req  = 1'b1;
    bus.dma_addr = 16'h0B00;
    bus.dma_wr   = 1'b0;
    for (int c = 0; c < 14; c++) begin
      ec = (c >= 1 && c <= 8) || c == 13;
      ed = (c >= 9 && c <= 12);
      if (ec) push(1'b0, 16'h0A00, 1'b1);
      if (ed) push(1'b1, 16'h0B00, 1'b0);
      @(negedge clk);
      checks++;
      if ({bus.cpu_gnt, bus.dma_gnt} !== {ec, ed}) begin
        errors++;
        $display("FAIL starve_c%0d got cpu=%0d dma=%0d exp cpu=%0d dma=%0d",
                 c, bus.cpu_gnt, bus.dma_gnt, ec, ed);
      end
      tick;
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_burst;
    logic ec;
    logic ed;
    tick;
    bus.cpu_addr = 16'h0500;
    bus.cpu_wr   = 1'b0;
    bus.dma_req  = 1'b1;
    bus.dma_addr = 16'h0400;
    bus.dma_wr   = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) bus.cpu_req = 1'b1;
      ec = (c == 5);
      ed = (c >= 1 && c <= 4);
      if (ec) push(1'b0, 16'h0500, 1'b0);
      if (ed) push(1'b1, 16'h0400, 1'b1);
      @(negedge clk);
      checks++;
      if ({bus.cpu_gnt, bus.dma_gnt} !== {ec, ed}) begin
        errors++;
        $display("FAIL burst_c%0d got cpu=%0d dma=%0d exp cpu=%0d dma=%0d",
                 c, bus.cpu_gnt, bus.dma_gnt, ec, ed);
      end
      tick;
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid_burst;
    tick;
    bus.dma_req  = 1'b1;
    bus.dma_addr = 16'h0600;
    bus.dma_wr   = 1'b1;
    push(1'b1, 16'h0600, 1'b1);
    tick;
    @(negedge clk);
    checks++;
    if (bus.dma_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_burst_gnt got %0d exp 1", bus.dma_gnt);
    end
    tick;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.dma_gnt, bus.mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL rst_async_drop got gnt=%0d en=%0d exp 0 0",
               bus.dma_gnt, bus.mem_en);
    end
    bus.dma_req = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.owner !== 2'd0 || dut.burst_cnt !== '0 ||
        dut.wait_cnt !== '0) begin
      errors++;
      $display("FAIL rst_state got owner=%0d burst=%0d wait=%0d exp 0",
               dut.owner, dut.burst_cnt, dut.wait_cnt);
    end
  endtask

  task automatic test_guard;
    tick;
    exec         = 1'b1;
    bus.dma_req  = 1'b1;
    bus.dma_addr = 16'h0280;
    bus.dma_wr   = 1'b1;
`ifdef VAPE_DMA_OR_GUARD_EN
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.dma_blocked, bus.dma_gnt} !== 2'b10 ||
          dut.wait_cnt !== '0) begin
        errors++;
        $display("FAIL guard_block_c%0d got blk=%0d gnt=%0d wait=%0d exp 1 0 0",
                 c, bus.dma_blocked, bus.dma_gnt, dut.wait_cnt);
      end
      tick;
    end
    bus.dma_addr = 16'h0300;
    push(1'b1, 16'h0300, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.dma_blocked, bus.dma_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL guard_outside_c0 got blk=%0d gnt=%0d exp 0 0",
               bus.dma_blocked, bus.dma_gnt);
    end
    tick;
    @(negedge clk);
    checks++;
    if (bus.dma_gnt !== 1'b1) begin
      errors++;
      $display("FAIL guard_outside_gnt got %0d exp 1", bus.dma_gnt);
    end
    tick;
    bus.dma_addr = 16'h0280;
    bus.dma_wr   = 1'b0;
    push(1'b1, 16'h0280, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.dma_blocked, bus.dma_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL guard_read got blk=%0d gnt=%0d exp 0 1",
               bus.dma_blocked, bus.dma_gnt);
    end
    tick;
    bus.dma_wr = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.dma_blocked, bus.dma_gnt, bus.mem_en} !== 3'b100) begin
      errors++;
      $display("FAIL guard_mid_owner got blk=%0d gnt=%0d en=%0d exp 1 0 0",
               bus.dma_blocked, bus.dma_gnt, bus.mem_en);
    end
    tick;
    @(negedge clk);
    checks++;
    if (dut.owner !== 2'd0) begin
      errors++;
      $display("FAIL guard_owner_leave got %0d exp 0", dut.owner);
    end
`else
    push(1'b1, 16'h0280, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.dma_blocked !== 1'b0) begin
      errors++;
      $display("FAIL noguard_blk got %0d exp 0", bus.dma_blocked);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({bus.dma_gnt, bus.mem_addr} !== {1'b1, 16'h0280}) begin
      errors++;
      $display("FAIL noguard_gnt got gnt=%0d addr=%h exp 1 0280",
               bus.dma_gnt, bus.mem_addr);
    end
`endif
    exec = 1'b0;
    idle;
  endtask

  task automatic test_drain;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL beats_missing got %0d pending exp 0", exp_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_cpu_single;
    test_starvation;
    test_burst;
    test_reset_mid_burst;
    test_guard;
    test_drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
